// File: rtl/bram_port_master.sv
// bram_port_master
// Turns a valid/ready request stream into accesses on a single-port block RAM
// with a registered (1-cycle) read port. It returns read data on a
// valid/ready response channel and keeps 16-bit counters of the writes
// accepted and the read responses completed.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request word address and write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             read data
//   mem_we/mem_addr/mem_din/mem_dout   block RAM port (dout registered)
//   rd_count, wr_count    completed reads / accepted writes, mod 2^16
module bram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RSP_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  accept;

    // A new request can enter while idle, or in the same cycle the held
    // response is consumed; nothing is accepted while reset is asserted.
    assign req_ready = !rst && ((state_q == IDLE) ||
                                ((state_q == RSP_HOLD) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // The memory port is driven straight from the accepted request so the RAM
    // sees it at the accept edge; otherwise the address parks on the last one.
    assign mem_we    = accept && req_we;
    assign mem_din   = req_wdata;
    assign mem_addr  = rst ? '0 : (accept ? req_addr : addr_q);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;

        if (accept) begin
            addr_d = req_addr;
        end
        if (accept && req_we) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept && !req_we) begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // RAM output now reflects the address presented at accept.
                rdata_d     = mem_dout;
                rsp_valid_d = 1'b1;
                state_d     = RSP_HOLD;
            end
            RSP_HOLD: begin
                if (rsp_ready) begin
                    rd_cnt_d    = rd_cnt_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = (accept && !req_we) ? READ_WAIT : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            rd_cnt_q    <= 16'd0;
            wr_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

endmodule

// File: tb/tb_bram_port_master.sv
// Testbench for bram_port_master: drives directed and random request/response
// traffic against a behavioural block RAM and a transaction-level model.
module tb_bram_port_master;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [15:0]   rd_count, wr_count;

    always #5 clk = ~clk;

    bram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    // Block RAM with registered read (read-first)
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b1;

    // Transaction-level model: shadow memory, one outstanding read at most
    logic [DW-1:0] sh [0:(1<<AW)-1];
    bit            m_pend;   // a read has been accepted and not yet consumed
    bit            m_have;   // its data is already being presented
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_last;
    logic [15:0]   m_rd, m_wr;
    bit            m_acc;
    logic [DW-1:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 17) ^ 8'h3C;
    endfunction

    // One clock cycle with the currently driven inputs
    task automatic cyc();
        bit            exp_rdy, acc, done;
        logic [AW-1:0] ea;
        #1;
        exp_rdy = !rst && (!m_pend || (m_have && rsp_ready));
        acc     = req_valid && exp_rdy;
        ea      = rst ? '0 : (acc ? req_addr : m_last);
        if (rsp_valid && rsp_ready) obs_q.push_back(rsp_rdata);
        if (chk_en) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("mem_we", mem_we, acc && req_we);
            chk("mem_addr", mem_addr, ea);
            if (acc && req_we) chk("mem_din", mem_din, req_wdata);
        end
        m_acc = acc;
        if (rst) begin
            m_pend = 0; m_have = 0; m_wr = 0; m_rd = 0; m_last = '0;
        end else begin
            done = m_pend && m_have && rsp_ready;
            if (done) begin
                m_rd++;
                m_pend = 0;
                m_have = 0;
            end else if (m_pend) begin
                m_have = 1;
            end
            if (acc) begin
                m_last = req_addr;
                if (req_we) begin
                    sh[req_addr] = req_wdata;
                    m_wr++;
                end else begin
                    m_pend = 1;
                    m_have = 0;
                    m_data = sh[req_addr];
                end
            end
        end
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("rsp_valid", rsp_valid, m_pend && m_have);
            if (m_pend && m_have) chk("rsp_rdata", rsp_rdata, m_data);
            chk("rd_count", rd_count, m_rd);
            chk("wr_count", wr_count, m_wr);
        end
    endtask

    initial begin
        logic [15:0] rd_base;
        int          na;

        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        m_pend = 0; m_have = 0; m_wr = 0; m_rd = 0; m_last = '0; m_data = '0;

        // Reset state, with a request offered that must not be taken
        req_valid = 1; req_we = 1; req_addr = 10'h155; req_wdata = 8'hFF;
        cyc();
        cyc();
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        req_valid = 0;
        rst = 0;

        // Write 0x005 <- 0xA5 then read it back
        req_valid = 1; req_we = 1; req_addr = 10'h005; req_wdata = 8'hA5; rsp_ready = 1;
        cyc();
        req_we = 0;
        cyc();                       // read accepted here; mem_we must be low
        req_valid = 0;
        cyc();                       // second edge after accept: response up
        chk("w_r_valid", rsp_valid, 1);
        chk("w_r_rdata", rsp_rdata, 8'hA5);
        cyc();
        chk("w_r_wrcnt", wr_count, 1);
        chk("w_r_rdcnt", rd_count, 1);

        // Fill 0x000..0x00F back-to-back
        for (int i = 0; i < 16; i++) begin
            req_valid = 1; req_we = 1; req_addr = AW'(i); req_wdata = pat(i);
            cyc();
        end
        req_valid = 0;

        // Back-pressured response held for 5 cycles, next read queued behind it
        rd_base = m_rd;
        req_valid = 1; req_we = 0; req_addr = 10'h003; rsp_ready = 0;
        cyc();
        req_addr = 10'h004;
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, pat(3));
            chk("hold_rdcnt", rd_count, rd_base);
        end
        rsp_ready = 1;
        cyc();                       // consume 0x003 and accept 0x004
        req_valid = 0;
        cyc();
        chk("hold_next_rdata", rsp_rdata, pat(4));
        cyc();
        chk("hold_rdcnt_after", rd_count, rd_base + 16'd2);

        // Streaming reads 0x000..0x00F at full rate
        obs_q.delete();
        na = 0;
        rsp_ready = 1;
        for (int c = 0; c < 34; c++) begin
            req_valid = (na < 16); req_we = 0; req_addr = AW'(na);
            cyc();
            if (m_acc) na++;
        end
        req_valid = 0;
        chk("stream_accepts", na, 16);
        chk("stream_count", obs_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < obs_q.size()) chk("stream_data", obs_q[i], pat(i));
        end

        // Write accepted in the cycle the response is consumed
        req_valid = 1; req_we = 0; req_addr = 10'h007; rsp_ready = 1;
        cyc();
        req_valid = 0;
        cyc();
        req_valid = 1; req_we = 1; req_addr = 10'h007; req_wdata = 8'h5A;
        cyc();
        chk("wh_valid0", rsp_valid, 0);
        req_valid = 0;
        cyc();
        chk("wh_valid1", rsp_valid, 0);
        chk("wh_ready", req_ready, 1);
        req_valid = 1; req_we = 0;
        cyc();
        req_valid = 0;
        cyc();
        chk("wh_rdata", rsp_rdata, 8'h5A);
        cyc();

        // Reset while the read is in flight
        req_valid = 1; req_we = 0; req_addr = 10'h002; rsp_ready = 1;
        cyc();
        req_valid = 0; rst = 1;
        cyc();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rr_valid", rsp_valid, 0);
        end
        chk("rr_rdata", rsp_rdata, 0);
        chk("rr_mem_addr", mem_addr, 0);
        chk("rr_mem_we", mem_we, 0);
        chk("rr_rdcnt", rd_count, 0);
        chk("rr_wrcnt", wr_count, 0);
        req_valid = 1;
        cyc();
        req_valid = 0;
        cyc();
        chk("rr_next_rdata", rsp_rdata, pat(2));
        cyc();
        chk("rr_next_rdcnt", rd_count, 1);

        // Random traffic over a small address window
        for (int k = 0; k < 400; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_valid = 0; rsp_ready = 1;
        cyc();
        cyc();
        cyc();

        // Write counter wrap
        rst = 1;
        cyc();
        rst = 0;
        chk_en = 0;
        req_valid = 1; req_we = 1; rsp_ready = 1;
        for (int i = 0; i < 65535; i++) begin
            req_addr = AW'(i & 15);
            req_wdata = DW'($urandom);
            cyc();
        end
        chk_en = 1;
        chk("wrap_ffff", wr_count, 16'hFFFF);
        cyc();
        chk("wrap_zero", wr_count, 0);
        req_valid = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_port_master.md
BRAM_PORT_MASTER -- requirements
Module: bram_port_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning a request is offered.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning a request can be accepted this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDR_WIDTH bits, meaning the request word address.
REQ-009 The block SHALL have port req_wdata, input, DATA_WIDTH bits, meaning the write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit, meaning read data is presented.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer takes the response.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits, meaning the read data.
REQ-013 The block SHALL have port mem_we, output, 1 bit, the memory write enable.
REQ-014 The block SHALL have port mem_addr, output, ADDR_WIDTH bits, the memory address.
REQ-015 The block SHALL have port mem_din, output, DATA_WIDTH bits, the memory write data.
REQ-016 The block SHALL have port mem_dout, input, DATA_WIDTH bits, the memory read data, registered with 1-cycle latency.
REQ-017 The block SHALL have port rd_count, output, 16 bits, the count of completed read responses.
REQ-018 The block SHALL have port wr_count, output, 16 bits, the count of accepted writes.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, READ_WAIT and RSP_HOLD.
REQ-020 The block SHALL define accept as req_valid && req_ready, where req_ready = (state==IDLE) || (state==RSP_HOLD && rsp_ready).
REQ-021 On accept, the block SHALL drive mem_addr=req_addr, mem_din=req_wdata and mem_we=req_we combinationally in the same cycle.
REQ-022 The block SHALL keep mem_we at 0 in every non-accept cycle or non-write accept.
REQ-023 In non-accept cycles, the block SHALL hold mem_addr at the last accepted address.
REQ-024 On an accepted write, the block SHALL increment wr_count modulo 2^16, and the next state SHALL be IDLE; writes produce no response.
REQ-025 On an accepted read, the next state SHALL be READ_WAIT.
REQ-026 In READ_WAIT, the block SHALL capture mem_dout into rsp_rdata at the clock edge, set rsp_valid=1, and the next state SHALL be RSP_HOLD; read latency is accept edge +2 edges to rsp_valid.
REQ-027 In READ_WAIT, req_ready SHALL be 0.
REQ-028 In RSP_HOLD, rsp_valid and rsp_rdata SHALL stay stable until rsp_ready=1.
REQ-029 In RSP_HOLD with rsp_ready=1, the block SHALL increment rd_count modulo 2^16 and complete the response.
REQ-030 If RSP_HOLD, rsp_ready=1 and no accept, the next state SHALL be IDLE with rsp_valid=0.
REQ-031 If RSP_HOLD, rsp_ready=1 and a read is accepted, the next state SHALL be READ_WAIT with rsp_valid=0; this gives one read per 2 cycles at full throughput.
REQ-032 If RSP_HOLD, rsp_ready=1 and a write is accepted, the block SHALL perform the write and the next state SHALL be IDLE.
REQ-033 A read issued in the cycle after a write to the same address SHALL return the new data; responses SHALL be returned in acceptance order (at most one outstanding).

Reset
REQ-034 While rst=1, the block SHALL force state=IDLE, rsp_valid=0, rsp_rdata=0, mem_addr=0, rd_count=0 and wr_count=0, with req_ready=0 and mem_we=0 (no accept during reset).
REQ-035 On rst asserted in READ_WAIT or RSP_HOLD, the block SHALL discard the pending read without a response and without a count change.

Verification
REQ-036 The bench SHALL check: write addr 0x005 data 0xA5, then read 0x005 -> mem_we pulse of 1 cycle; rsp_valid 2 edges after read accept, rsp_rdata=0xA5, wr_count=1, rd_count=1.
REQ-037 The bench SHALL check: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready=0 throughout, rd_count unchanged until rsp_ready=1.
REQ-038 The bench SHALL check: continuous reads of 0x000..0x00F with rsp_ready=1 -> 16 responses in address order over 32 cycles, with data matching the written pattern.
REQ-039 The bench SHALL check: write issued in the RSP_HOLD+rsp_ready cycle -> response completes and the write lands, state returns to IDLE, and no spurious rsp_valid.
REQ-040 The bench SHALL check: rst asserted in READ_WAIT -> no rsp_valid afterwards, all outputs 0, and the next read works normally.
REQ-041 The bench SHALL check: 65536 writes -> wr_count wraps to 0.
